rv32_mem_immgen: RTL and testbench
==================================

# rv32_mem_immgen

Single-cycle RV32I support block grouping the instruction ROM, the word-addressed data RAM and the immediate generator. It sits between the PC register and the register file/ALU of the single-cycle core. The PC and ALU result drive the memory word addresses, and the fetched instruction drives the immediate generator. Memory reads are combinational; data writes commit on the clock edge.

## Interface
- ADDR_W, 6: word-address width for both memories; depth is 2^ADDR_W words of 32 bits.
- clk  in  1  single clock; data memory writes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- imem_addr  in  ADDR_W  instruction word index (core drives PC[7:2]).
- imem_data  out  32  instruction at imem_addr.
- dmem_read  in  1  data memory read enable.
- dmem_write  in  1  data memory write enable.
- dmem_addr  in  ADDR_W  data word index (core drives ALU result[7:2]).
- dmem_wdata  in  32  write data (rs2).
- dmem_rdata  out  32  read data.
- imm_inst  in  32  instruction to decode.
- imm_out  out  32  generated immediate.

## Operation
- Instruction ROM:
  - Combinational: imem_data = rom[imem_addr].
  - Contents are unaffected by reset.
  - Default contents: word0 0x00002083 (lw x1,0(x0)); word1 0x00402103 (lw x2,4(x0)); word2 0x002081B3 (add x3,x1,x2); word3 0x00302423 (sw x3,8(x0)).
  - All other words hold 0x00000033 (NOP-equivalent add x0,x0,x0).
- Data RAM:
  - dmem_rdata = ram[dmem_addr] when dmem_read=1, else 32'h0.
  - Read is combinational.
  - On the rising clk with dmem_write=1 and rst=1: ram[dmem_addr] <= dmem_wdata.
  - Reset values: word0 = 17, word1 = 9, all other words 0.
  - dmem_read and dmem_write may both be 1; they are independent.
- Immediate generator: purely combinational, decoded on imm_inst[6:2].
  - 00000 LOAD, 00100 OP-IMM, 11001 JALR (I-type): sext(inst[31:20]).
    - Shift-immediates are not special-cased; srai yields 0x400|shamt.
  - 01000 STORE (S-type): sext({inst[31:25], inst[11:7]}).
  - 11000 BRANCH (B-type): sext({inst[31], inst[7], inst[30:25], inst[11:8]}).
    - This is the offset in halfword units, bit 0 dropped; the core shifts it left by 1.
  - 11011 JAL (J-type): sext({inst[31], inst[19:12], inst[20], inst[30:21]}).
    - Also in halfword units.
  - 01101 LUI, 00101 AUIPC (U-type): {inst[31:12], 12'h000}.
  - Any other opcode, including R-type 01100: 32'h0.
- Sign extension always uses inst[31].

## Timing
- imem_data, dmem_rdata and imm_out have zero-cycle combinational latency.
- Write latency: the data is visible on dmem_rdata immediately after the capturing edge.
- Read and write to the same address in the same cycle: before the edge, dmem_rdata shows old data; after the edge, it shows new data.
- Reset:
  - rst low immediately (asynchronously) restores the RAM reset values.
  - Writes are ignored while rst=0.
  - Reset deasserted mid-operation: the first write takes effect on the first rising edge with rst=1.
- No handshake; every access completes in the cycle it is presented.
- Addresses wrap naturally within ADDR_W bits; there are no out-of-range accesses.

## Test plan
- Pulse rst low, read dmem words 0/1/2 with dmem_read=1 -> 17, 9, 0. With dmem_read=0 -> 0.
- Write 0x0000001A to word 2; read back word 2 -> 0x1A.
  - Same write with rst held low -> still 0.
  - Assert rst low afterwards -> word 2 returns to 0 without a clock edge.
- Sweep imem_addr 0..4 -> 0x00002083, 0x00402103, 0x002081B3, 0x00302423, 0x00000033.
- imm_inst 0xFFF00093 -> 0xFFFFFFFF.
  - 0x00302423 -> 0x00000008.
  - 0x002081B3 -> 0x00000000.
- imm_inst 0x00000463 (beq +8) -> 0x00000004.
  - 0x010000EF (jal +16) -> 0x00000008.
  - 0x123452B7 (lui) -> 0x12345000.
- In one cycle, read word 3 with dmem_read=1 and write 0xDEADBEEF to word 3.
  - Before the edge -> old value 0.
  - After the edge -> 0xDEADBEEF.

Source files
------------

// File: rtl/rv32_mem_immgen.sv
// Single-cycle RV32I memory/immediate block: instruction ROM, word-addressed data RAM
// and the immediate generator, all with combinational read paths.
module rv32_mem_immgen #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [31:0]       dmem_wdata,
    output logic [31:0]       dmem_rdata,
    input  logic [31:0]       imm_inst,
    output logic [31:0]       imm_out
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [4:0] {
        OPC_LOAD   = 5'b00000,
        OPC_OP_IMM = 5'b00100,
        OPC_AUIPC  = 5'b00101,
        OPC_STORE  = 5'b01000,
        OPC_LUI    = 5'b01101,
        OPC_BRANCH = 5'b11000,
        OPC_JALR   = 5'b11001,
        OPC_JAL    = 5'b11011
    } opc_e;

    logic [31:0] ram [DEPTH];

    // Fixed program: two loads, an add, and a store of the sum; the rest are NOPs.
    always_comb begin
        imem_data = 32'h0000_0033;
        case (imem_addr)
            ADDR_W'(0): imem_data = 32'h0000_2083;
            ADDR_W'(1): imem_data = 32'h0040_2103;
            ADDR_W'(2): imem_data = 32'h0020_81B3;
            ADDR_W'(3): imem_data = 32'h0030_2423;
            default:    imem_data = 32'h0000_0033;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= 32'd0;
            end
            ram[0] <= 32'd17;
            ram[1] <= 32'd9;
        end else if (dmem_write) begin
            ram[dmem_addr] <= dmem_wdata;
        end
    end

    assign dmem_rdata = dmem_read ? ram[dmem_addr] : 32'h0;

    // Branch and jump offsets stay in halfword units; the core adds the implicit zero LSB.
    always_comb begin
        imm_out = 32'h0;
        case (opc_e'(imm_inst[6:2]))
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                imm_out = {{20{imm_inst[31]}}, imm_inst[31:20]};
            OPC_STORE:
                imm_out = {{20{imm_inst[31]}}, imm_inst[31:25], imm_inst[11:7]};
            OPC_BRANCH:
                imm_out = {{20{imm_inst[31]}}, imm_inst[31], imm_inst[7],
                           imm_inst[30:25], imm_inst[11:8]};
            OPC_JAL:
                imm_out = {{12{imm_inst[31]}}, imm_inst[31], imm_inst[19:12],
                           imm_inst[20], imm_inst[30:21]};
            OPC_LUI, OPC_AUIPC:
                imm_out = {imm_inst[31:12], 12'h000};
            default:
                imm_out = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_rv32_mem_immgen.sv
// Directed bench for rv32_mem_immgen: RAM reset/write behaviour, ROM contents and
// immediate decoding, each scenario checked inline against hand-computed values.
module tb_rv32_mem_immgen;

    logic        clk;
    logic        rst;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        dmem_read;
    logic        dmem_write;
    logic [5:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [31:0] imm_inst;
    logic [31:0] imm_out;

    int n_cmp;
    int n_err;

    rv32_mem_immgen #(.ADDR_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .imm_inst   (imm_inst),
        .imm_out    (imm_out)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        logic [31:0] exp_vals [3];
        exp_vals[0] = 32'd17;
        exp_vals[1] = 32'd9;
        exp_vals[2] = 32'd0;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            dmem_read = 1'b1;
            dmem_addr = 6'(i);
            #1;
            n_cmp++;
            if (dmem_rdata !== exp_vals[i]) begin
                n_err++;
                $display("FAIL reset_word%0d: got %h expected %h", i, dmem_rdata, exp_vals[i]);
            end
            dmem_read = 1'b0;
            #1;
            n_cmp++;
            if (dmem_rdata !== 32'h0) begin
                n_err++;
                $display("FAIL read_disabled_word%0d: got %h expected 00000000", i, dmem_rdata);
            end
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        dmem_addr  = 6'd2;
        dmem_wdata = 32'h0000_001A;
        dmem_write = 1'b1;
        dmem_read  = 1'b1;
        @(posedge clk);
        #1;
        dmem_write = 1'b0;
        n_cmp++;
        if (dmem_rdata !== 32'h0000_001A) begin
            n_err++;
            $display("FAIL write_word2: got %h expected 0000001a", dmem_rdata);
        end
        // word 0 must be untouched by the write to word 2
        dmem_addr = 6'd0;
        #1;
        n_cmp++;
        if (dmem_rdata !== 32'd17) begin
            n_err++;
            $display("FAIL write_other_word0: got %h expected 00000011", dmem_rdata);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        dmem_addr = 6'd2;
        dmem_read = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (dmem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset_word2: got %h expected 00000000", dmem_rdata);
        end
        rst = 1'b1;
    endtask

    task automatic test_write_in_reset();
        @(negedge clk);
        rst        = 1'b0;
        dmem_addr  = 6'd2;
        dmem_wdata = 32'h0000_001A;
        dmem_write = 1'b1;
        dmem_read  = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dmem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL write_in_reset: got %h expected 00000000", dmem_rdata);
        end
        // release reset with a write pending: the next rising edge must commit it
        @(negedge clk);
        rst        = 1'b1;
        dmem_wdata = 32'h0000_0055;
        #1;
        n_cmp++;
        if (dmem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL write_before_first_edge: got %h expected 00000000", dmem_rdata);
        end
        @(posedge clk);
        #1;
        dmem_write = 1'b0;
        n_cmp++;
        if (dmem_rdata !== 32'h0000_0055) begin
            n_err++;
            $display("FAIL write_after_release: got %h expected 00000055", dmem_rdata);
        end
    endtask

    task automatic test_rom();
        logic [31:0] exp_rom [6];
        exp_rom[0] = 32'h0000_2083;
        exp_rom[1] = 32'h0040_2103;
        exp_rom[2] = 32'h0020_81B3;
        exp_rom[3] = 32'h0030_2423;
        exp_rom[4] = 32'h0000_0033;
        exp_rom[5] = 32'h0000_0033;
        for (int i = 0; i < 6; i++) begin
            imem_addr = (i == 5) ? 6'd63 : 6'(i);
            #1;
            n_cmp++;
            if (imem_data !== exp_rom[i]) begin
                n_err++;
                $display("FAIL rom_addr%0d: got %h expected %h", imem_addr, imem_data, exp_rom[i]);
            end
        end
    endtask

    task automatic test_imm();
        logic [31:0] ins [12];
        logic [31:0] exp_imm [12];
        ins[0]  = 32'hFFF0_0093; exp_imm[0]  = 32'hFFFF_FFFF; // addi x1,x0,-1
        ins[1]  = 32'h0030_2423; exp_imm[1]  = 32'h0000_0008; // sw x3,8(x0)
        ins[2]  = 32'h0020_81B3; exp_imm[2]  = 32'h0000_0000; // add (R-type)
        ins[3]  = 32'h0000_0463; exp_imm[3]  = 32'h0000_0004; // beq +8
        ins[4]  = 32'h0100_00EF; exp_imm[4]  = 32'h0000_0008; // jal +16
        ins[5]  = 32'h1234_52B7; exp_imm[5]  = 32'h1234_5000; // lui
        ins[6]  = 32'h4050_D093; exp_imm[6]  = 32'h0000_0405; // srai x1,x1,5
        ins[7]  = 32'hABCD_E017; exp_imm[7]  = 32'hABCD_E000; // auipc
        ins[8]  = 32'h8000_80E7; exp_imm[8]  = 32'hFFFF_F800; // jalr -2048
        ins[9]  = 32'hFE00_0EE3; exp_imm[9]  = 32'hFFFF_FFFE; // beq -4
        ins[10] = 32'hFE11_2E23; exp_imm[10] = 32'hFFFF_FFFC; // sw -4
        ins[11] = 32'h8000_006F; exp_imm[11] = 32'hFFF8_0000; // jal, most negative
        for (int i = 0; i < 12; i++) begin
            imm_inst = ins[i];
            #1;
            n_cmp++;
            if (imm_out !== exp_imm[i]) begin
                n_err++;
                $display("FAIL imm_%h: got %h expected %h", ins[i], imm_out, exp_imm[i]);
            end
        end
    endtask

    task automatic test_same_cycle_rw();
        @(negedge clk);
        dmem_addr  = 6'd3;
        dmem_read  = 1'b1;
        dmem_write = 1'b1;
        dmem_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (dmem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rw_before_edge: got %h expected 00000000", dmem_rdata);
        end
        @(posedge clk);
        #1;
        dmem_write = 1'b0;
        n_cmp++;
        if (dmem_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL rw_after_edge: got %h expected deadbeef", dmem_rdata);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        imem_addr  = '0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        imm_inst   = '0;

        test_reset();
        test_write();
        test_async_reset();
        test_write_in_reset();
        test_rom();
        test_imm();
        test_same_cycle_rw();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
